// File: rtl/coin_pulse_conditioner.sv
// Coin-chute front end: synchronise, debounce and edge-detect nickel/dime sensors, then
// arbitrate into exclusive one-cycle pulses. Optional per-coin counters under COIN_COUNT_EN.
module coin_pulse_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MIN_GAP         = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic nickel_raw,
  input  logic dime_raw,
  output logic nickel,
  output logic dime,
  output logic reject,
  output logic busy
`ifdef COIN_COUNT_EN
  ,
  output logic [7:0] nickel_count,
  output logic [7:0] dime_count
`endif
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_GAP - 1);

  typedef enum logic [1:0] {IDLE, EMIT_N, EMIT_D, HOLD} state_t;

  // bit 0 = nickel channel, bit 1 = dime channel
  logic [1:0]    s1, s2, deb, deb_q;
  logic [CW-1:0] cnt [2];

  state_t        state;
  logic [HW-1:0] hcnt;
  logic          pend_n, pend_d;
  logic [1:0]    rise;
  logic          collide, take_n, take_d;
  logic          pend_n_nxt, pend_d_nxt, reject_nxt;

  // Synchronise and debounce: a level is accepted only after a full stable window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      deb    <= '0;
      deb_q  <= '0;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      s1    <= {dime_raw, nickel_raw};
      s2    <= s1;
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LAST) begin
          cnt[i] <= '0;
          deb[i] <= ~deb[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Pending-coin bookkeeping: simultaneous arrivals collide, arrivals on a pending channel overrun
  always_comb begin
    rise       = deb & ~deb_q;
    collide    = rise[0] & rise[1];
    take_d     = (state == IDLE) & pend_d;
    take_n     = (state == IDLE) & ~pend_d & pend_n;
    pend_n_nxt = (pend_n & ~take_n) | (rise[0] & ~rise[1] & ~pend_n);
    pend_d_nxt = (pend_d & ~take_d) | (rise[1] & ~rise[0] & ~pend_d);
    reject_nxt = collide | (rise[0] & ~rise[1] & pend_n) | (rise[1] & ~rise[0] & pend_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_n <= 1'b0;
      pend_d <= 1'b0;
      reject <= 1'b0;
    end else begin
      pend_n <= pend_n_nxt;
      pend_d <= pend_d_nxt;
      reject <= reject_nxt;
    end
  end

  // Arbiter: dime wins, one pulse per grant, then a holdoff before the next grant.
  // busy is registered from next-cycle values so it tracks pend/state without lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      hcnt   <= '0;
      nickel <= 1'b0;
      dime   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      nickel <= 1'b0;
      dime   <= 1'b0;
      case (state)
        IDLE: begin
          if (take_d) begin
            state <= EMIT_D;
            dime  <= 1'b1;
            busy  <= 1'b1;
          end else if (take_n) begin
            state  <= EMIT_N;
            nickel <= 1'b1;
            busy   <= 1'b1;
          end else begin
            busy <= pend_n_nxt | pend_d_nxt;
          end
        end
        EMIT_N, EMIT_D: begin
          state <= HOLD;
          hcnt  <= '0;
          busy  <= 1'b1;
        end
        HOLD: begin
          if (hcnt == HOLD_LAST) begin
            state <= IDLE;
            busy  <= pend_n_nxt | pend_d_nxt;
          end else begin
            hcnt <= hcnt + HW'(1);
            busy <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef COIN_COUNT_EN
  // Saturating accepted-coin counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nickel_count <= '0;
      dime_count   <= '0;
    end else begin
      if (nickel && (nickel_count != 8'hFF)) nickel_count <= nickel_count + 8'd1;
      if (dime && (dime_count != 8'hFF))     dime_count   <= dime_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Bench for coin_pulse_conditioner: directed scenarios plus random sensor waveforms,
// every cycle scored against an event-level model of debounce, arbitration and holdoff.
module tb_coin_pulse_conditioner;

  localparam int unsigned D = 16;
  localparam int unsigned G = 1;

  logic clk = 1'b0;
  logic rst, nickel_raw, dime_raw;
  logic nickel, dime, reject, busy;
`ifdef COIN_COUNT_EN
  logic [7:0] nickel_count, dime_count;
`endif

  always #5 clk = ~clk;

  coin_pulse_conditioner #(.DEBOUNCE_CYCLES(D), .MIN_GAP(G)) dut (
    .clk        (clk),
    .rst        (rst),
    .nickel_raw (nickel_raw),
    .dime_raw   (dime_raw),
    .nickel     (nickel),
    .dime       (dime),
    .reject     (reject),
    .busy       (busy)
`ifdef COIN_COUNT_EN
    ,
    .nickel_count (nickel_count),
    .dime_count   (dime_count)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // model state: edge index since reset release, raw history, accepted levels, pend, holdoff
  int   e;
  logic hist_n[$];
  logic hist_d[$];
  logic acc[2];
  int   run[2];
  logic rose_prev[2];
  logic pend[2];
  int   next_take;
  logic exp_n, exp_d, exp_r, exp_b;
  bit   mdl_on = 1'b0;

  int n_pulses = 0, d_pulses = 0, r_pulses = 0;
  int last_n_edge = -1, last_d_edge = -1;

  task automatic model_reset();
    e = 0;
    hist_n.delete();
    hist_d.delete();
    for (int c = 0; c < 2; c++) begin
      acc[c] = 1'b0; run[c] = 0; rose_prev[c] = 1'b0; pend[c] = 1'b0;
    end
    next_take = 0;
  endtask

  task automatic model_step(input logic rn, input logic rd);
    logic s[2];
    logic arr[2];
    logic newp[2];
    logic collide, ovr, take_n, take_d;
    hist_n.push_back(rn);
    hist_d.push_back(rd);
    // the sensor value seen by the debouncer lags the pin by two samples
    s[0] = (e >= 2) ? hist_n[e-2] : 1'b0;
    s[1] = (e >= 2) ? hist_d[e-2] : 1'b0;
    for (int c = 0; c < 2; c++) begin
      arr[c] = rose_prev[c];
      rose_prev[c] = 1'b0;
      if (s[c] !== acc[c]) begin
        run[c]++;
        if (run[c] == int'(D)) begin
          acc[c] = ~acc[c];
          run[c] = 0;
          rose_prev[c] = acc[c];
        end
      end else begin
        run[c] = 0;
      end
    end
    collide = arr[0] && arr[1];
    ovr     = !collide && ((arr[0] && pend[0]) || (arr[1] && pend[1]));
    take_d  = (e >= next_take) && pend[1];
    take_n  = (e >= next_take) && !pend[1] && pend[0];
    newp[0] = (pend[0] && !take_n) || (arr[0] && !collide && !pend[0]);
    newp[1] = (pend[1] && !take_d) || (arr[1] && !collide && !pend[1]);
    if (take_n || take_d) next_take = e + 2 + int'(G);
    pend  = newp;
    exp_n = take_n;
    exp_d = take_d;
    exp_r = collide || ovr;
    exp_b = pend[0] || pend[1] || (e <= next_take - 2);
    e++;
  endtask

  // per-edge scoreboard
  always @(posedge clk) begin
    if (mdl_on && !rst) begin
      model_step(nickel_raw, dime_raw);
      #1;
      vectors += 5;
      if (nickel !== exp_n) begin
        miscompares++;
        $display("FAIL nickel @edge %0d: got %b expected %b", e-1, nickel, exp_n);
      end
      if (dime !== exp_d) begin
        miscompares++;
        $display("FAIL dime @edge %0d: got %b expected %b", e-1, dime, exp_d);
      end
      if (reject !== exp_r) begin
        miscompares++;
        $display("FAIL reject @edge %0d: got %b expected %b", e-1, reject, exp_r);
      end
      if (busy !== exp_b) begin
        miscompares++;
        $display("FAIL busy @edge %0d: got %b expected %b", e-1, busy, exp_b);
      end
      if (nickel === 1'b1 && dime === 1'b1) begin
        miscompares++;
        $display("FAIL exclusive @edge %0d: got nickel=1 dime=1 expected not both", e-1);
      end
      if (nickel === 1'b1) begin n_pulses++; last_n_edge = e - 1; end
      if (dime === 1'b1)   begin d_pulses++; last_d_edge = e - 1; end
      if (reject === 1'b1) r_pulses++;
    end
  end

  task automatic drive(input logic n, input logic d);
    @(negedge clk);
    nickel_raw = n;
    dime_raw   = d;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    vectors += 4;
    if (nickel !== 1'b0) begin miscompares++; $display("FAIL reset_nickel: got %b expected 0", nickel); end
    if (dime !== 1'b0)   begin miscompares++; $display("FAIL reset_dime: got %b expected 0", dime); end
    if (reject !== 1'b0) begin miscompares++; $display("FAIL reset_reject: got %b expected 0", reject); end
    if (busy !== 1'b0)   begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_five_nickels();
    int n0 = n_pulses;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 20; i++) drive(1'b1, 1'b0);
      idle(20);
    end
    idle(5);
    vectors++;
    if (n_pulses - n0 !== 5) begin
      miscompares++;
      $display("FAIL five_nickels: got %0d pulses expected 5", n_pulses - n0);
    end
`ifdef COIN_COUNT_EN
    vectors++;
    if (nickel_count !== 8'd5) begin
      miscompares++;
      $display("FAIL nickel_count: got %0d expected 5", nickel_count);
    end
`endif
  endtask

  task automatic test_clean_nickel();
    int n0 = n_pulses, d0 = d_pulses, r0 = r_pulses, e0;
    drive(1'b1, 1'b0);
    e0 = e;
    for (int i = 0; i < 29; i++) drive(1'b1, 1'b0);
    idle(25);
    vectors += 3;
    if (n_pulses - n0 !== 1) begin
      miscompares++; $display("FAIL clean_nickel_count: got %0d expected 1", n_pulses - n0);
    end
    if (last_n_edge !== e0 + 19) begin
      miscompares++; $display("FAIL clean_nickel_latency: got edge %0d expected %0d", last_n_edge, e0 + 19);
    end
    if ((d_pulses - d0) + (r_pulses - r0) !== 0) begin
      miscompares++; $display("FAIL clean_nickel_side: got %0d dime/reject pulses expected 0",
                              (d_pulses - d0) + (r_pulses - r0));
    end
  endtask

  task automatic test_dime_bounce();
    int d0 = d_pulses;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
    end
    vectors++;
    if (d_pulses - d0 !== 0) begin
      miscompares++; $display("FAIL bounce_quiet: got %0d pulses expected 0", d_pulses - d0);
    end
    for (int i = 0; i < 30; i++) drive(1'b0, 1'b1);
    idle(25);
    vectors++;
    if (d_pulses - d0 !== 1) begin
      miscompares++; $display("FAIL bounce_dime: got %0d pulses expected 1", d_pulses - d0);
    end
  endtask

  task automatic test_collision();
    int n0 = n_pulses, d0 = d_pulses, r0 = r_pulses;
    for (int i = 0; i < 30; i++) drive(1'b1, 1'b1);
    idle(25);
    vectors += 2;
    if (r_pulses - r0 !== 1) begin
      miscompares++; $display("FAIL collision_reject: got %0d expected 1", r_pulses - r0);
    end
    if ((n_pulses - n0) + (d_pulses - d0) !== 0) begin
      miscompares++; $display("FAIL collision_coins: got %0d pulses expected 0",
                              (n_pulses - n0) + (d_pulses - d0));
    end
  endtask

  task automatic test_back_to_back();
    int e0;
    drive(1'b0, 1'b1);
    e0 = e;
    drive(1'b0, 1'b1);
    for (int i = 0; i < 28; i++) drive(1'b1, 1'b1);
    idle(25);
    vectors += 3;
    if (last_d_edge !== e0 + 19) begin
      miscompares++; $display("FAIL b2b_dime: got edge %0d expected %0d", last_d_edge, e0 + 19);
    end
    if (last_n_edge !== e0 + 22) begin
      miscompares++; $display("FAIL b2b_nickel: got edge %0d expected %0d", last_n_edge, e0 + 22);
    end
    if (last_n_edge - last_d_edge - 1 < int'(G)) begin
      miscompares++; $display("FAIL b2b_gap: got %0d low cycles expected >= %0d",
                              last_n_edge - last_d_edge - 1, G);
    end
  endtask

  task automatic test_random();
    int   left[2];
    logic lvl[2];
    left[0] = 0; left[1] = 0; lvl[0] = 1'b0; lvl[1] = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (left[c] == 0) begin
          lvl[c]  = 1'($urandom_range(1));
          left[c] = ($urandom_range(1) == 1) ? int'($urandom_range(6, 1))
                                              : int'($urandom_range(60, 17));
        end
        left[c]--;
      end
      drive(lvl[0], lvl[1]);
    end
    idle(40);
  endtask

  task automatic test_reset_mid_pulse();
    int  n_after;
    bit  seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      drive(1'b1, 1'b0);
      if (nickel === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++; $display("FAIL midreset_wait: got no nickel in 40 cycles expected a pulse");
    end
    mdl_on = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors += 2;
    if (nickel !== 1'b0) begin
      miscompares++; $display("FAIL midreset_nickel: got %b expected 0", nickel);
    end
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL midreset_busy: got %b expected 0", busy);
    end
    nickel_raw = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
    mdl_on = 1'b1;
    n_after = n_pulses;
    idle(40);
    vectors += 2;
    if (n_pulses !== n_after) begin
      miscompares++; $display("FAIL midreset_nopulse: got %0d pulses expected 0", n_pulses - n_after);
    end
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL midreset_idle_busy: got %b expected 0", busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    nickel_raw = 1'b0;
    dime_raw = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    model_reset();
    rst = 1'b0;
    mdl_on = 1'b1;
    test_five_nickels();
    test_clean_nickel();
    test_dime_bounce();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
